acc_start_ctrl: RTL and testbench

Initiator side of the accelerator start/finish handshake. It exposes a 32-bit Avalon-MM slave register file to the HPS lightweight bridge and issues a single-cycle start pulse to the accelerator. It then waits for the finish rising edge, measures run latency in clock cycles, and enforces an optional timeout. Done and timeout can each raise a level interrupt. It sits in the GHRD between the HPS bridge and the accelerator top.

---
 rtl/acc_ctrl_pkg.sv | 27 ++
 rtl/acc_start_ctrl_if.sv | 18 +
 rtl/acc_latency_counter.sv | 34 +++
 rtl/acc_start_ctrl.sv | 144 ++++++++++++++
 tb/tb_acc_start_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_ctrl_pkg.sv
// rtl/acc_ctrl_pkg.sv - shared register map, bit positions and FSM encoding for the accelerator start controller
package acc_ctrl_pkg;

   localparam int CNT_W_DEFAULT = 64;

   localparam logic [2:0] ADDR_CTRL    = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_CYC_LO  = 3'd2;
   localparam logic [2:0] ADDR_CYC_HI  = 3'd3;
   localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
   localparam logic [2:0] ADDR_RUNS    = 3'd5;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_IRQ     = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/acc_start_ctrl_if.sv
// rtl/acc_start_ctrl_if.sv - memory-mapped register bus between the host bridge and the start controller
interface acc_start_ctrl_if;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/acc_latency_counter.sv
// rtl/acc_latency_counter.sv - saturating run-latency counter with a snapshot register
module acc_latency_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             snap,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] cycles
);

   // Free-running count for the current run; holds at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

   // Latency of the most recent completed or timed-out run
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles <= '0;
      end else if (snap) begin
         cycles <= count;
      end
   end

endmodule

// File: rtl/acc_start_ctrl.sv
// rtl/acc_start_ctrl.sv - register-driven start/finish handshake initiator with latency measurement and timeout
module acc_start_ctrl
   import acc_ctrl_pkg::*;
#(
   parameter int          CNT_W           = CNT_W_DEFAULT,
   parameter logic [31:0] DEFAULT_TIMEOUT = 32'd0
) (
   input  logic             clk,
   input  logic             reset,
   acc_start_ctrl_if.slave  avs,
   output logic             o_start,
   input  logic             i_finish,
   output logic             o_busy,
   output logic             o_irq
);

   state_t           state;
   logic             finish_q;
   logic             done_flag;
   logic             to_flag;
   logic             irq_en;
   logic [31:0]      timeout_reg;
   logic [31:0]      shadow;
   logic [31:0]      runs;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cycles;
   logic [CNT_W-1:0] shadow_ext;
   logic [63:0]      cyc64;

   logic wr_ctrl, wr_status, wr_timeout, go_req;
   logic finish_rise, limit_hit, in_wait;

   assign wr_ctrl     = avs.avs_write && (avs.avs_address == ADDR_CTRL);
   assign wr_status   = avs.avs_write && (avs.avs_address == ADDR_STATUS);
   assign wr_timeout  = avs.avs_write && (avs.avs_address == ADDR_TIMEOUT);
   assign go_req      = wr_ctrl && avs.avs_writedata[CTRL_GO];
   assign finish_rise = i_finish && !finish_q;
   assign shadow_ext  = CNT_W'(shadow);
   assign limit_hit   = (shadow != 32'd0) && (count == shadow_ext);
   assign in_wait     = (state == WAIT);
   assign cyc64       = 64'(cycles);

   acc_latency_counter #(.CNT_W(CNT_W)) u_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == START),
      .enable (in_wait && !finish_rise && !limit_hit),
      .snap   (in_wait && (finish_rise || limit_hit)),
      .count  (count),
      .cycles (cycles)
   );

   // Registered copy of finish for rising-edge detection
   always_ff @(posedge clk) begin
      if (reset) finish_q <= 1'b0;
      else       finish_q <= i_finish;
   end

   // Run sequencing, sticky flags and run counter; hardware flag sets override a same-cycle W1C
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         o_start   <= 1'b0;
         o_busy    <= 1'b0;
         done_flag <= 1'b0;
         to_flag   <= 1'b0;
         shadow    <= 32'd0;
         runs      <= 32'd0;
      end else begin
         if (wr_status) begin
            if (avs.avs_writedata[STAT_DONE])    done_flag <= 1'b0;
            if (avs.avs_writedata[STAT_TIMEOUT]) to_flag   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (go_req) begin
                  state     <= START;
                  o_start   <= 1'b1;
                  o_busy    <= 1'b1;
                  done_flag <= 1'b0;
                  to_flag   <= 1'b0;
                  shadow    <= timeout_reg;
               end
            end
            START: begin
               o_start <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               if (finish_rise) begin
                  done_flag <= 1'b1;
                  runs      <= runs + 32'd1;
                  state     <= IDLE;
                  o_busy    <= 1'b0;
               end else if (limit_hit) begin
                  to_flag <= 1'b1;
                  state   <= IDLE;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               o_start <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Host-writable configuration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en      <= 1'b0;
         timeout_reg <= DEFAULT_TIMEOUT;
      end else begin
         if (wr_ctrl)    irq_en      <= avs.avs_writedata[CTRL_IRQ_EN];
         if (wr_timeout) timeout_reg <= avs.avs_writedata;
      end
   end

   // Level interrupt, one cycle behind the flags
   always_ff @(posedge clk) begin
      if (reset) o_irq <= 1'b0;
      else       o_irq <= irq_en && (done_flag || to_flag);
   end

   // Read mux with one-cycle latency; data holds between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         avs.avs_readdata <= 32'd0;
      end else if (avs.avs_read) begin
         case (avs.avs_address)
            ADDR_CTRL:    avs.avs_readdata <= {30'd0, irq_en, 1'b0};
            ADDR_STATUS:  avs.avs_readdata <= {28'd0, o_irq, to_flag, done_flag, o_busy};
            ADDR_CYC_LO:  avs.avs_readdata <= cyc64[31:0];
            ADDR_CYC_HI:  avs.avs_readdata <= cyc64[63:32];
            ADDR_TIMEOUT: avs.avs_readdata <= timeout_reg;
            ADDR_RUNS:    avs.avs_readdata <= runs;
            default:      avs.avs_readdata <= 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_start_ctrl.sv
// tb/tb_acc_start_ctrl.sv - scoreboard bench for the accelerator start controller
module tb_acc_start_ctrl;
   import acc_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic o_start, o_busy, o_irq;
   logic fin = 1'b0;

   acc_start_ctrl_if bus ();

   acc_start_ctrl #(.CNT_W(64), .DEFAULT_TIMEOUT(32'd0)) dut (
      .clk      (clk),
      .reset    (reset),
      .avs      (bus),
      .o_start  (o_start),
      .i_finish (fin),
      .o_busy   (o_busy),
      .o_irq    (o_irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // accelerator model: finish rises N cycles after start is sampled, held until next start
   int   acc_n = 10;
   int   acc_cnt = 0;
   logic acc_run = 1'b0;
   always @(posedge clk) begin
      if (reset) begin
         fin <= 1'b0; acc_run <= 1'b0; acc_cnt <= 0;
      end else if (o_start) begin
         fin <= 1'b0; acc_run <= 1'b1; acc_cnt <= 1;
      end else if (acc_run) begin
         if (acc_cnt == acc_n) begin
            fin <= 1'b1; acc_run <= 1'b0;
         end else begin
            acc_cnt <= acc_cnt + 1;
         end
      end
   end

   int start_pulses = 0;
   always @(posedge clk) if (o_start) start_pulses <= start_pulses + 1;

   // read scoreboard
   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic        rd_d = 1'b0;
   always @(posedge clk) rd_d <= bus.avs_read;
   always @(negedge clk) begin
      logic [31:0] e;
      string       t;
      if (rd_d) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {32'd0, bus.avs_readdata}, {32'd0, e});
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
      @(negedge clk);
      bus.avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
      bus.avs_address = a; bus.avs_read = 1'b1;
      @(negedge clk);
      bus.avs_read = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (o_busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle", {63'd0, o_busy}, 64'd0);
   endtask

   task automatic wait_fin(input logic lvl);
      int k = 0;
      while (fin !== lvl && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("wait_fin", {63'd0, fin}, {63'd0, lvl});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      bus.avs_address = 3'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_start", {63'd0, o_start}, 64'd0);
      chk("rst_busy",  {63'd0, o_busy}, 64'd0);
      chk("rst_irq",   {63'd0, o_irq}, 64'd0);
      chk("rst_rdata", {32'd0, bus.avs_readdata}, 64'd0);
      reset = 1'b0;
      tick();
      for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("rst_addr%0d", a));

      // basic run, N=10
      acc_n = 10;
      bus_write(ADDR_CTRL, 32'h1);
      chk("t2_start_hi", {63'd0, o_start}, 64'd1);
      chk("t2_busy",     {63'd0, o_busy}, 64'd1);
      tick();
      chk("t2_start_lo", {63'd0, o_start}, 64'd0);
      bus_read(ADDR_STATUS, 32'h1, "t2_status_busy");
      wait_idle();
      tick();
      bus_read(ADDR_STATUS, 32'h2, "t2_status_done");
      bus_read(ADDR_CYC_LO, 32'd10, "t2_cyc_lo");
      bus_read(ADDR_CYC_HI, 32'd0, "t2_cyc_hi");
      bus_read(ADDR_RUNS, 32'd1, "t2_runs");
      chk("t2_pulses", 64'(start_pulses), 64'd1);

      // timeout with interrupt
      bus_write(ADDR_TIMEOUT, 32'd5);
      bus_write(ADDR_CTRL, 32'h3);
      wait_idle();
      tick(); tick();
      chk("t3_irq", {63'd0, o_irq}, 64'd1);
      bus_read(ADDR_STATUS, 32'hC, "t3_status");
      bus_read(ADDR_CYC_LO, 32'd5, "t3_cyc_lo");
      bus_read(ADDR_CTRL, 32'h2, "t3_ctrl");
      repeat (15) tick();
      bus_read(ADDR_STATUS, 32'hC, "t3_status_late");
      bus_read(ADDR_CYC_LO, 32'd5, "t3_cyc_late");
      bus_read(ADDR_RUNS, 32'd1, "t3_runs_late");
      bus_write(ADDR_STATUS, 32'h4);
      chk("t3_irq_lag", {63'd0, o_irq}, 64'd1);
      tick();
      chk("t3_irq_clr", {63'd0, o_irq}, 64'd0);
      bus_read(ADDR_STATUS, 32'h0, "t3_status_clr");

      // repeated GO during WAIT
      bus_write(ADDR_TIMEOUT, 32'd0);
      acc_n = 20;
      p0 = start_pulses;
      bus_write(ADDR_CTRL, 32'h1);
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         bus_write(ADDR_CTRL, 32'h1);
         tick();
      end
      wait_idle();
      tick();
      chk("t4_pulses", 64'(start_pulses - p0), 64'd1);
      bus_read(ADDR_CYC_LO, 32'd20, "t4_cyc_lo");
      bus_read(ADDR_RUNS, 32'd2, "t4_runs");
      bus_read(ADDR_STATUS, 32'h2, "t4_status");

      // finish and timeout in the same cycle
      bus_write(ADDR_TIMEOUT, 32'd10);
      acc_n = 10;
      bus_write(ADDR_CTRL, 32'h1);
      wait_idle();
      tick();
      bus_read(ADDR_STATUS, 32'h2, "t5_tie_status");
      bus_read(ADDR_CYC_LO, 32'd10, "t5_tie_cyc");
      bus_read(ADDR_RUNS, 32'd3, "t5_tie_runs");

      // W1C DONE in the same cycle as finish detection
      bus_write(ADDR_TIMEOUT, 32'd0);
      bus_write(ADDR_CTRL, 32'h1);
      wait_fin(1'b0);
      wait_fin(1'b1);
      bus_write(ADDR_STATUS, 32'h2);
      wait_idle();
      tick();
      bus_read(ADDR_STATUS, 32'h2, "t5_w1c_status");
      bus_read(ADDR_RUNS, 32'd4, "t5_w1c_runs");

      // reset in the middle of WAIT
      bus_write(ADDR_TIMEOUT, 32'd50);
      acc_n = 20;
      bus_write(ADDR_CTRL, 32'h1);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      chk("t6_busy",  {63'd0, o_busy}, 64'd0);
      chk("t6_start", {63'd0, o_start}, 64'd0);
      chk("t6_irq",   {63'd0, o_irq}, 64'd0);
      reset = 1'b0;
      tick();
      bus_read(ADDR_STATUS, 32'h0, "t6_status");
      bus_read(ADDR_CYC_LO, 32'd0, "t6_cyc_lo");
      bus_read(ADDR_RUNS, 32'd0, "t6_runs");
      bus_read(ADDR_TIMEOUT, 32'd0, "t6_timeout");
      acc_n = 7;
      bus_write(ADDR_CTRL, 32'h1);
      wait_idle();
      tick();
      bus_read(ADDR_CYC_LO, 32'd7, "t6_cyc_after");
      bus_read(ADDR_STATUS, 32'h2, "t6_status_after");
      bus_read(ADDR_RUNS, 32'd1, "t6_runs_after");

      tick();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
